aes_blk_feeder: RTL
===================

Name: aes_blk_feeder

Overview:
Word-serial front/back end for the AES-128 cipher core.
- Assembles 32-bit host words into a 128-bit key and 128-bit text block.
- Issues a one-cycle ld pulse to the core with key/text_in held stable.
- Waits for done, captures the core's text_out, and returns the result as four 32-bit words over a valid/ready port.
- Sits directly upstream and downstream of the cipher core; the core's ld/key/text_in/text_out/done connect straight to this block.

Parameters:
TIMEOUT_CYC, 64, max cycles waited in WAIT for core_done before flagging err; legal range 16..1023.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  host word valid
wr_ready  out  1  block accepts host word
wr_sel  in  1  0 = text word, 1 = key word
wr_data  in  32  host word; word 0 = bits 127:96, word 3 = bits 31:0
ld  out  1  one-cycle load strobe to core
key  out  128  key to core
text_in  out  128  plaintext to core
core_text_out  in  128  core result
core_done  in  1  core done (level or pulse)
rd_valid  out  1  result word valid
rd_ready  in  1  host accepts result word
rd_data  out  32  result word, MSB word first
busy  out  1  high in LAUNCH/WAIT/DRAIN
err  out  1  sticky: timeout or launch without full key; cleared on next successful launch or rst

Behaviour:
- Single clock domain. Reset is synchronous, active-high. All state is updated only on clk rising edge.
- Reset values: ld=0, key=0, text_in=0, rd_valid=0, rd_data=0, busy=0, err=0. wr_ready=1 (combinational from state IDLE). State=IDLE; text_cnt=0, key_cnt=0, key_full=0; result=0; timeout counter=0.
- FSM states: IDLE, LAUNCH, WAIT, DRAIN.
- IDLE:
  - wr_ready=1. A write happens on wr_valid & wr_ready.
  - wr_sel=1: write key word key_cnt, then key_cnt+1 mod 4. key_full sets when word 3 is written; it stays set until rst.
  - wr_sel=0: write text word text_cnt, then text_cnt+1.
  - When text word 3 is written:
    - if key_full (including key_full set in an earlier cycle) -> LAUNCH, text_cnt=0.
    - else err=1, text_cnt=0, stay in IDLE, no ld.
- LAUNCH (1 cycle): ld=1, busy=1, err cleared, timeout counter=0 -> WAIT. key/text_in stay stable from LAUNCH until the next IDLE write.
- WAIT:
  - ld=0. The first WAIT cycle is a guard cycle: core_done is ignored there, because a stale done level from a previous op may still be high.
  - From the 2nd WAIT cycle on, core_done=1 -> result <= core_text_out, go to DRAIN.
  - Timeout counter increments each WAIT cycle. If it reaches TIMEOUT_CYC with no done: err=1, go to IDLE, no result is produced.
  - core_done and timeout in the same cycle: done wins.
- DRAIN:
  - rd_valid=1, rd_data=result word rd_cnt (rd_cnt 0..3).
  - Advance on rd_valid & rd_ready. rd_data holds while rd_ready=0.
  - After word 3 is accepted: rd_valid=0, go to IDLE.
- wr_ready=0 outside IDLE; host writes are stalled, not dropped.
- Min latency: last text word accepted at cycle N -> ld at N+1 -> result word 0 valid at done+1.
- rst asserted in any state (including mid-WAIT/DRAIN) returns everything to reset values in the next cycle. A core done arriving afterwards is ignored.
- Back-to-back blocks: after DRAIN the key is retained. Four new text words launch the next op without rewriting the key.

Optional Feature:
AES_BYTE_SWAP_EN
- Defined: each 32-bit word is byte-reversed on input (wr_data, both key and text) and on output (rd_data). Used for little-endian hosts. Word ordering is unchanged.
- Undefined: words pass unmodified, big-endian byte order (byte 0 = bits 31:24).

Test Plan:
- FIPS-197 vector: key words 00010203,04050607,08090a0b,0c0d0e0f; text 00112233,44556677,8899aabb,ccddeeff; core = aes_cipher_top -> one ld pulse; rd_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; err=0.
- rd_ready held low 5 cycles per word in DRAIN -> rd_data/rd_valid stable; wr_ready=0 throughout; returns to IDLE after 4th handshake.
- Text written with only 2 key words after rst -> no ld, err=1; finish key, resend text -> ld, err clears at LAUNCH.
- Core model never asserts done (TIMEOUT_CYC=16) -> err=1 after 16 WAIT cycles, rd_valid never 1, wr_ready=1 again.
- Stale done: core_done held high before LAUNCH and in the guard cycle, low after, real done 11 cycles later -> captures the later result, not the stale one. Also rst mid-WAIT -> all outputs at reset values next cycle, following done ignored.
- With AES_BYTE_SWAP_EN: byte-reversed FIPS inputs (03020100,...) -> rd_data d8e0c469,30047b6a,80b7cdd8,5ac5b470.

Source files
------------

// File: rtl/aes_blk_feeder.sv
// aes_blk_feeder: word-serial front/back end for an AES-128 cipher core.
//
// Collects 32-bit host words into a 128-bit key and text block. It pulses ld
// to the core for one cycle, then waits for core_done. It captures text_out
// and streams the result back as four 32-bit words over valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_valid/wr_ready   host write handshake; wr_sel 0 = text, 1 = key
//   wr_data             host word, word 0 = bits 127:96
//   ld, key, text_in    load strobe and operands to the core
//   core_text_out       core result, captured on core_done
//   core_done           core completion (level or pulse)
//   rd_valid/rd_ready   result handshake; rd_data = result word, MSB word first
//   busy                high in LAUNCH/WAIT/DRAIN
//   err                 sticky: timeout or text completed without a full key
//
// Optional feature: define AES_BYTE_SWAP_EN to byte-reverse every host word
// on input and output (little-endian hosts). Word order is unaffected.

module aes_blk_feeder #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic         wr_sel,
    input  logic [31:0]  wr_data,
    output logic         ld,
    output logic [127:0] key,
    output logic [127:0] text_in,
    input  logic [127:0] core_text_out,
    input  logic         core_done,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [31:0]  rd_data,
    output logic         busy,
    output logic         err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Counter value in the last permitted WAIT cycle.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    // Element [3] holds word 0 (bits 127:96), so word n lives at index ~n.
    logic [3:0][31:0] key_q, key_d;
    logic [3:0][31:0] text_q, text_d;
    logic [3:0][31:0] result_q, result_d;
    logic [1:0]       key_cnt_q, key_cnt_d;
    logic [1:0]       text_cnt_q, text_cnt_d;
    logic [1:0]       rd_cnt_q, rd_cnt_d;
    logic             key_full_q, key_full_d;
    logic [9:0]       tmo_q, tmo_d;
    logic             err_q, err_d;

    logic [31:0]      wr_word;
    logic [31:0]      rd_word;

`ifdef AES_BYTE_SWAP_EN
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign wr_word = bswap(wr_data);
    assign rd_word = bswap(result_q[~rd_cnt_q]);
`else
    assign wr_word = wr_data;
    assign rd_word = result_q[~rd_cnt_q];
`endif

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        text_d     = text_q;
        result_d   = result_q;
        key_cnt_d  = key_cnt_q;
        text_cnt_d = text_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        key_full_d = key_full_q;
        tmo_d      = tmo_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    if (wr_sel) begin
                        key_d[~key_cnt_q] = wr_word;
                        key_cnt_d         = key_cnt_q + 2'd1;
                        if (key_cnt_q == 2'd3) key_full_d = 1'b1;
                    end else begin
                        text_d[~text_cnt_q] = wr_word;
                        text_cnt_d          = text_cnt_q + 2'd1;  // wraps to 0 after word 3
                        if (text_cnt_q == 2'd3) begin
                            if (key_full_q) begin
                                state_d = ST_LAUNCH;
                                err_d   = 1'b0;
                            end else begin
                                err_d   = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_LAUNCH: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // tmo_q == 0 is the guard cycle: a stale done level is ignored.
                if (core_done && (tmo_q != '0)) begin
                    result_d = core_text_out;
                    rd_cnt_d = '0;
                    state_d  = ST_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            ST_DRAIN: begin
                if (rd_ready) begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                    if (rd_cnt_q == 2'd3) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            text_q     <= '0;
            result_q   <= '0;
            key_cnt_q  <= '0;
            text_cnt_q <= '0;
            rd_cnt_q   <= '0;
            key_full_q <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            text_q     <= text_d;
            result_q   <= result_d;
            key_cnt_q  <= key_cnt_d;
            text_cnt_q <= text_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            key_full_q <= key_full_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign wr_ready = (state_q == ST_IDLE);
    assign ld       = (state_q == ST_LAUNCH);
    assign busy     = (state_q != ST_IDLE);
    assign rd_valid = (state_q == ST_DRAIN);
    assign rd_data  = rd_valid ? rd_word : 32'h0;
    assign key      = key_q;
    assign text_in  = text_q;
    assign err      = err_q;

endmodule
